// File: rtl/slot_arbiter.sv
// Round-robin time-slot arbiter: one requester owns the grant for up to slot_len cycles.
// Latency: grant, slot_start and slot_cnt are registered, visible one cycle after the deciding edge.
// Backpressure: enable=0 blocks new slots, but the current slot always runs to completion.
module slot_arbiter #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [NREQ-1:0]  req,
    input  logic [CNT_W-1:0] slot_len,
    input  logic             resync,
    output logic [NREQ-1:0]  grant,
    output logic             slot_start,
    output logic             busy,
    output logic [CNT_W-1:0] slot_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic             slot_start_q, slot_start_d;
    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [PW-1:0]    last_q, last_d;
    logic             resync_meta_q, resync_s_q;

    logic             resync_s;
    logic [PW-1:0]    cand;
    logic [PW-1:0]    win_idx;
    logic             win_vld;
    logic             start_ok;
    logic             slot_end;
    logic             take;

    // Two-flop synchronizer for the asynchronous abort request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resync_meta_q <= 1'b0;
            resync_s_q    <= 1'b0;
        end else begin
            resync_meta_q <= resync;
            resync_s_q    <= resync_meta_q;
        end
    end

    assign resync_s = resync_s_q;

    // Search downward so the last hit is the first set bit above last_q.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = PW'((int'(last_q) + i) % NREQ);
            if (req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign start_ok = enable && win_vld;
    assign slot_end = (slot_cnt_q == (len_q - CNT_W'(1))) || ((req & grant_q) == '0);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        slot_start_d = 1'b0;
        slot_cnt_d   = slot_cnt_q;
        len_d        = len_q;
        last_d       = last_q;
        take         = 1'b0;

        if (resync_s) begin
            state_d    = IDLE;
            grant_d    = '0;
            slot_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    grant_d    = '0;
                    slot_cnt_d = '0;
                    take       = start_ok;
                end
                RUN: begin
                    if (slot_end) begin
                        if (start_ok) begin
                            take = 1'b1;
                        end else begin
                            state_d    = IDLE;
                            grant_d    = '0;
                            slot_cnt_d = '0;
                        end
                    end else begin
                        slot_cnt_d = slot_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    slot_cnt_d = '0;
                end
            endcase
        end

        if (take) begin
            state_d      = RUN;
            grant_d      = NREQ'(1) << win_idx;
            slot_start_d = 1'b1;
            slot_cnt_d   = '0;
            len_d        = (slot_len == '0) ? CNT_W'(1) : slot_len;
            last_d       = win_idx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            slot_start_q <= 1'b0;
            slot_cnt_q   <= '0;
            len_q        <= CNT_W'(1);
            last_q       <= PW'(NREQ - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            slot_start_q <= slot_start_d;
            slot_cnt_q   <= slot_cnt_d;
            len_q        <= len_d;
            last_q       <= last_d;
        end
    end

    assign grant      = grant_q;
    assign slot_start = slot_start_q;
    assign busy       = (state_q == RUN);
    assign slot_cnt   = slot_cnt_q;

endmodule

// File: tb/tb_slot_arbiter.sv
// Directed bench for slot_arbiter: expected output cycles are queued with each stimulus
// step and popped one per clock as the DUT produces them.
module tb_slot_arbiter;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] req;
    logic [7:0] slot_len;
    logic       resync;
    logic [3:0] grant;
    logic       slot_start;
    logic       busy;
    logic [7:0] slot_cnt;

    typedef struct {
        logic [3:0] g;
        logic       s;
        logic       b;
        logic [7:0] c;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    slot_arbiter #(.NREQ(4), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .req        (req),
        .slot_len   (slot_len),
        .resync     (resync),
        .grant      (grant),
        .slot_start (slot_start),
        .busy       (busy),
        .slot_cnt   (slot_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic push(input logic [3:0] g, input logic s, input logic b, input logic [7:0] c);
        exp_t e;
        e.g = g; e.s = s; e.b = b; e.c = c;
        sb.push_back(e);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed grant=%b", tag, grant);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (grant === e.g) else begin
                errors++;
                $error("FAIL %s grant: observed=%b expected=%b", tag, grant, e.g);
            end
            checks++;
            assert (slot_start === e.s) else begin
                errors++;
                $error("FAIL %s slot_start: observed=%b expected=%b", tag, slot_start, e.s);
            end
            checks++;
            assert (busy === e.b) else begin
                errors++;
                $error("FAIL %s busy: observed=%b expected=%b", tag, busy, e.b);
            end
            checks++;
            assert (slot_cnt === e.c) else begin
                errors++;
                $error("FAIL %s slot_cnt: observed=%0d expected=%0d", tag, slot_cnt, e.c);
            end
            checks++;
            assert ($onehot0(grant)) else begin
                errors++;
                $error("FAIL %s onehot: observed=%b expected=at most one bit", tag, grant);
            end
        end
    endtask

    // Sample one cycle after the edge; the caller then drives the next inputs.
    task automatic cycle(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            compare(tag);
        end
    endtask

    initial begin
        reset    = 1'b0;
        enable   = 1'b0;
        req      = 4'b0000;
        slot_len = 8'd0;
        resync   = 1'b0;
        #12;
        push(4'b0000, 1'b0, 1'b0, 8'd0);
        compare("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Back-to-back 3-cycle slots: requester 0 then 2.
        enable   = 1'b1;
        req      = 4'b0101;
        slot_len = 8'd3;
        push(4'b0001, 1, 1, 0); push(4'b0001, 0, 1, 1); push(4'b0001, 0, 1, 2);
        push(4'b0100, 1, 1, 0); push(4'b0100, 0, 1, 1); push(4'b0100, 0, 1, 2);
        cycle("rr_len3", 6);
        req = 4'b0000;
        push(4'b0000, 0, 0, 0);
        cycle("rr_len3_idle", 1);

        // slot_len=0 acts as L=1: a fresh slot every cycle.
        req      = 4'b0010;
        slot_len = 8'd0;
        repeat (4) push(4'b0010, 1, 1, 0);
        cycle("len0", 4);
        req = 4'b0000;
        push(4'b0000, 0, 0, 0);
        cycle("len0_idle", 1);

        // Early release at slot_cnt=1.
        req      = 4'b0100;
        slot_len = 8'd5;
        push(4'b0100, 1, 1, 0); push(4'b0100, 0, 1, 1);
        cycle("early_run", 2);
        req = 4'b0000;
        push(4'b0000, 0, 0, 0);
        cycle("early_rel", 1);

        // Resync pulse at slot_cnt=2; pointer is 2 so requester 0 wins, then 1.
        req      = 4'b0011;
        slot_len = 8'd8;
        push(4'b0001, 1, 1, 0); push(4'b0001, 0, 1, 1); push(4'b0001, 0, 1, 2);
        cycle("resync_pre", 3);
        resync = 1'b1;
        push(4'b0001, 0, 1, 3);
        cycle("resync_e1", 1);
        resync = 1'b0;
        push(4'b0001, 0, 1, 4);
        cycle("resync_e2", 1);
        push(4'b0000, 0, 0, 0);
        cycle("resync_e3", 1);
        push(4'b0010, 1, 1, 0); push(4'b0010, 0, 1, 1);
        cycle("resync_next", 2);

        // Enable dropped mid-slot: the 8-cycle slot still completes.
        req    = 4'b1111;
        enable = 1'b0;
        for (int c = 2; c < 8; c++) push(4'b0010, 0, 1, 8'(c));
        push(4'b0000, 0, 0, 0); push(4'b0000, 0, 0, 0);
        cycle("enable_off", 8);

        // Asynchronous reset mid-slot, then requester 3 gets first grant.
        enable   = 1'b1;
        slot_len = 8'd4;
        push(4'b0100, 1, 1, 0); push(4'b0100, 0, 1, 1);
        cycle("pre_reset", 2);
        #1;
        reset = 1'b0;
        #1;
        push(4'b0000, 0, 0, 0);
        compare("async_reset");
        @(posedge clk);
        #1;
        req   = 4'b1000;
        reset = 1'b1;
        push(4'b1000, 1, 1, 0); push(4'b1000, 0, 1, 1);
        cycle("post_reset", 2);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain: observed=%0d expected=0 entries left", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/slot_arbiter.md
SLOT_ARBITER -- requirements
Module: slot_arbiter

Interface
REQ-001 Parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-002 Parameter CNT_W, default 8, meaning width of slot length and slot counter.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  synchronous; 0 blocks new grants, current slot runs to completion.
REQ-006 req  input  NREQ  per-requester request level.
REQ-007 slot_len  input  CNT_W  slot length in cycles; sampled at each slot start.
REQ-008 resync  input  1  asynchronous abort/realign request, active-high.
REQ-009 grant  output  NREQ  one-hot grant, registered.
REQ-010 slot_start  output  1  one-cycle pulse, high in the first cycle of every slot.
REQ-011 busy  output  1  high while in RUN.
REQ-012 slot_cnt  output  CNT_W  cycles elapsed in the current slot, 0 in first cycle.

Function
REQ-013 resync SHALL pass a 2-flop synchronizer; only the synchronized value resync_s SHALL be used.
REQ-014 FSM states SHALL be IDLE and RUN only.
REQ-015 IDLE: if enable=1 and req!=0 at a rising edge, the next state SHALL be RUN, with grant, slot_start=1 and slot_cnt=0 visible in the following cycle.
REQ-016 Winner SHALL be selected round-robin: first set req bit searching upward from (last granted index + 1) mod NREQ.
REQ-017 Effective length L SHALL be slot_len latched at slot start, with slot_len=0 treated as L=1.
REQ-018 RUN: slot_cnt SHALL increment by 1 per cycle; slot ends in the cycle where slot_cnt==L-1.
REQ-019 Early release: if the granted requester's req bit is 0 in a RUN cycle, that cycle SHALL be treated as the last cycle of the slot.
REQ-020 At slot end, if enable=1 and req!=0, a new slot SHALL start in the next cycle with no gap; the same requester MAY win again only if no other bit is set.
REQ-021 At slot end, if enable=0 or req==0, the next state SHALL be IDLE with grant=0.
REQ-022 grant SHALL never be multi-hot; grant SHALL be 0 in IDLE.
REQ-023 slot_start SHALL never be high in two consecutive cycles unless L=1 or an early release occurs.
REQ-024 resync_s=1 SHALL take priority over all other events: next state IDLE, grant=0, slot_cnt=0, slot_start=0, the round-robin pointer kept.
REQ-025 While resync_s=1, no grant SHALL be issued; arbitration resumes the cycle after resync_s falls.
REQ-026 slot_cnt SHALL not wrap: L is at most 2^CNT_W-1.

Reset
REQ-027 reset=0 SHALL immediately force IDLE, grant=0, slot_start=0, busy=0, slot_cnt=0, both synchronizer flops=0, latched L=1.
REQ-028 Reset SHALL set the last-granted pointer to NREQ-1, so requester 0 has first priority.
REQ-029 Reset asserted mid-slot SHALL clear grant asynchronously, without waiting for a clock edge.
REQ-030 Release of reset SHALL be synchronized externally; the block needs no first-cycle behaviour beyond REQ-027.

Verification
REQ-031 The bench SHALL cover: req=4'b0101, slot_len=3, enable=1 -> grant 0001 for 3 cycles, then 0100 for 3 cycles back-to-back; slot_start pulses at cycles 1 and 4; slot_cnt 0,1,2,0,1,2.
REQ-032 The bench SHALL cover: req=4'b0010, slot_len=0 -> grant 0010 every cycle; slot_start high continuously; slot_cnt stays 0.
REQ-033 The bench SHALL cover: slot_len=5, req[2] alone, req[2] dropped at slot_cnt=1 -> that cycle is last; grant=0 and busy=0 next cycle.
REQ-034 The bench SHALL cover: slot_len=8, resync pulse held 1 cycle at slot_cnt=2 -> grant=0 on the 3rd rising edge after assertion; next grant goes to the next requester in round-robin order.
REQ-035 The bench SHALL cover: enable dropped mid-slot with req=4'b1111 -> current slot completes its full L cycles, then IDLE, grant=0.
REQ-036 The bench SHALL cover: reset=0 pulse mid-slot -> grant=0 immediately; after release with req=4'b1000, first grant is 1000 and slot_cnt restarts at 0.
